// File: rtl/doa_pkg.sv
// Shared constants, state encoding and elaboration helpers for the DOA peak search.
package doa_pkg;

    localparam int POWER_WIDTH_DEF = 32'sd71;
    localparam int N_ANGLES_DEF    = 32'sd181;
    localparam int ANGLE_BITS_DEF  = 32'sd8;
    localparam int N_SNAP_DEF      = 32'sd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Ceiling log2, used to size the accumulator and the snapshot counter.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 32'sd0;
        span   = 32'sd1;
        while (span < value) begin
            span   = span * 32'sd2;
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/doa_peak_search_peak_hold.sv
// Running maximum / argmax register. A forced load takes the first angle
// unconditionally; afterwards only a strictly greater value replaces the
// stored one, so on ties the earliest (lowest) index is kept.
module peak_hold #(
    parameter int VAL_W = 32'sd72,
    parameter int IDX_W = 32'sd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic             force_i,
    input  logic [VAL_W-1:0] val_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [VAL_W-1:0] max_o,
    output logic [IDX_W-1:0] max_idx_o
);

    logic [VAL_W-1:0] max_q;
    logic [IDX_W-1:0] max_idx_q;
    logic             load_s;

    // Decide whether the presented value becomes the new maximum.
    always_comb begin
        load_s = 1'b0;
        if (upd_i && (force_i || (val_i > max_q))) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Hold the running maximum and its index; clear has priority over update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q     <= '0;
            max_idx_q <= '0;
        end else if (clr_i) begin
            max_q     <= '0;
            max_idx_q <= '0;
        end else if (load_s) begin
            max_q     <= val_i;
            max_idx_q <= idx_i;
        end else begin
            max_q     <= max_q;
            max_idx_q <= max_idx_q;
        end
    end

    assign max_o     = max_q;
    assign max_idx_o = max_idx_q;

endmodule

// File: rtl/doa_peak_search.sv
// Direction-of-arrival peak search: sweeps the steering index, accumulates
// N_SNAP beam-power samples per angle and reports the strongest angle.
module doa_peak_search
    import doa_pkg::*;
#(
    parameter  int POWER_WIDTH = POWER_WIDTH_DEF,
    parameter  int N_ANGLES    = N_ANGLES_DEF,
    parameter  int ANGLE_BITS  = ANGLE_BITS_DEF,
    parameter  int N_SNAP      = N_SNAP_DEF,
    localparam int ACC_WIDTH   = POWER_WIDTH + clog2(N_SNAP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [POWER_WIDTH-1:0] pwr_in,
    input  logic                   pwr_valid,
    output logic                   pwr_ready,
    output logic [ANGLE_BITS-1:0]  steer_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   peak_valid,
    output logic [ANGLE_BITS-1:0]  peak_idx,
    output logic [ACC_WIDTH-1:0]   peak_pwr
);

    // Snapshot counter needs at least one bit even when N_SNAP is 1.
    localparam int SNAP_BITS = (clog2(N_SNAP) > 32'sd0) ? clog2(N_SNAP) : 32'sd1;
    localparam logic [SNAP_BITS-1:0]  LAST_SNAP  = SNAP_BITS'(N_SNAP - 32'sd1);
    localparam logic [ANGLE_BITS-1:0] LAST_ANGLE = ANGLE_BITS'(N_ANGLES - 32'sd1);

    state_e                  state_q;
    logic [ANGLE_BITS-1:0]   steer_q;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    acc_d;
    logic [SNAP_BITS-1:0]    snap_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    peak_valid_q;
    logic [ANGLE_BITS-1:0]   peak_idx_q;
    logic [ACC_WIDTH-1:0]    peak_pwr_q;

    logic                    hs_s;
    logic                    clr_s;
    logic                    upd_s;
    logic                    force_s;
    logic [ACC_WIDTH-1:0]    max_s;
    logic [ANGLE_BITS-1:0]   max_idx_s;

    // Handshake, accumulator next value and control strobes for the peak tracker.
    always_comb begin
        hs_s    = ready_q & pwr_valid;
        acc_d   = acc_q + ACC_WIDTH'(pwr_in);
        clr_s   = 1'b0;
        upd_s   = 1'b0;
        force_s = (steer_q == '0);
        if (state_q == ST_IDLE) begin
            clr_s = start & ~abort;
            upd_s = 1'b0;
        end else begin
            clr_s = abort;
            upd_s = (state_q == ST_COMPARE) & ~abort;
        end
    end

    peak_hold #(
        .VAL_W (ACC_WIDTH),
        .IDX_W (ANGLE_BITS)
    ) u_peak_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_s),
        .upd_i     (upd_s),
        .force_i   (force_s),
        .val_i     (acc_q),
        .idx_i     (steer_q),
        .max_o     (max_s),
        .max_idx_o (max_idx_s)
    );

    // Scan sequencer: state, counters, accumulator and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            steer_q      <= '0;
            acc_q        <= '0;
            snap_q       <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_pwr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                // Cancel: drop partial results and return to idle without a done pulse.
                state_q      <= ST_IDLE;
                steer_q      <= '0;
                acc_q        <= '0;
                snap_q       <= '0;
                ready_q      <= 1'b0;
                busy_q       <= 1'b0;
                peak_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        steer_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (abort) begin
                            peak_valid_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else if (start) begin
                            acc_q        <= '0;
                            snap_q       <= '0;
                            peak_valid_q <= 1'b0;
                            busy_q       <= 1'b1;
                            ready_q      <= 1'b1;
                            state_q      <= ST_ACCUM;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ACCUM: begin
                        if (hs_s) begin
                            acc_q <= acc_d;
                            if (snap_q == LAST_SNAP) begin
                                snap_q  <= '0;
                                ready_q <= 1'b0;
                                state_q <= ST_COMPARE;
                            end else begin
                                snap_q <= snap_q + SNAP_BITS'(1);
                            end
                        end else begin
                            acc_q  <= acc_q;
                            snap_q <= snap_q;
                        end
                    end
                    ST_COMPARE: begin
                        // The peak tracker samples acc_q on this same edge.
                        if (steer_q == LAST_ANGLE) begin
                            ready_q <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            steer_q <= steer_q + ANGLE_BITS'(1);
                            acc_q   <= '0;
                            snap_q  <= '0;
                            ready_q <= 1'b1;
                            state_q <= ST_ACCUM;
                        end
                    end
                    ST_DONE: begin
                        peak_idx_q   <= max_idx_s;
                        peak_pwr_q   <= max_s;
                        peak_valid_q <= 1'b1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        ready_q      <= 1'b0;
                        steer_q      <= '0;
                        state_q      <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        steer_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pwr_ready  = ready_q;
    assign steer_idx  = steer_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign peak_valid = peak_valid_q;
    assign peak_idx   = peak_idx_q;
    assign peak_pwr   = peak_pwr_q;

endmodule

// File: tb/tb_doa_peak_search.sv
// Self-checking bench: a 4-angle/2-snapshot instance for functional scenarios
// and a default-parameter instance for full-width and full-latency checks.
module tb_doa_peak_search;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Small instance (N_ANGLES=4, N_SNAP=2)
    logic          start_a, abort_a, pwr_valid_a;
    logic [70:0]   pwr_a;
    logic          ready_a, busy_a, done_a, pv_a;
    logic [7:0]    steer_a, pidx_a;
    logic [71:0]   ppwr_a;
    logic [70:0]   tab_a [0:3];

    // Default instance
    logic          start_b, abort_b, pwr_valid_b;
    logic [70:0]   pwr_b;
    logic          ready_b, busy_b, done_b, pv_b;
    logic [7:0]    steer_b, pidx_b;
    logic [74:0]   ppwr_b;

    // Combinational upstream power stage: power depends only on the steering index.
    assign pwr_a = tab_a[steer_a[1:0]];

    doa_peak_search #(.N_ANGLES(4), .N_SNAP(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .pwr_in(pwr_a), .pwr_valid(pwr_valid_a), .pwr_ready(ready_a),
        .steer_idx(steer_a), .busy(busy_a), .done(done_a), .peak_valid(pv_a),
        .peak_idx(pidx_a), .peak_pwr(ppwr_a)
    );

    doa_peak_search dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .pwr_in(pwr_b), .pwr_valid(pwr_valid_b), .pwr_ready(ready_b),
        .steer_idx(steer_b), .busy(busy_b), .done(done_b), .peak_valid(pv_b),
        .peak_idx(pidx_b), .peak_pwr(ppwr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: accumulated power per angle is 2*tab; lowest index wins ties.
    task automatic model_a(output logic [7:0] idx, output logic [71:0] pwr);
        logic [71:0] s;
        idx = 8'd0;
        pwr = 72'd0;
        for (int a = 0; a < 4; a++) begin
            s = 72'(tab_a[a]) * 72'd2;
            if (a == 0 || s > pwr) begin
                pwr = s;
                idx = 8'(a);
            end
        end
    endtask

    task automatic fill_random_tab();
        for (int a = 0; a < 4; a++) begin
            case ($urandom_range(0, 2))
                0:       tab_a[a] = 71'($urandom_range(0, 3));
                1:       tab_a[a] = 71'({$urandom(), $urandom(), $urandom()});
                default: tab_a[a] = tab_a[0];
            endcase
        end
    endtask

    // Start a scan on instance A with pwr_valid held high; report done latency.
    task automatic scan_a(input int budget, output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        pwr_valid_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1) begin
                lat = n;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0]  e_idx;
        logic [71:0] e_pwr;
        int lat;
        bit to;
        repeat (3) @(negedge clk);
        total++;
        if ({ready_a, steer_a, busy_a, done_a, pv_a, pidx_a, ppwr_a, ready_b, busy_b, done_b, pv_b} !== '0) begin
            bad++;
            $display("FAIL reset_initial got=%h required=0",
                     {ready_a, steer_a, busy_a, done_a, pv_a, pidx_a, ppwr_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Mid-scan asynchronous reset.
        tab_a[0] = 71'd5; tab_a[1] = 71'd6; tab_a[2] = 71'd7; tab_a[3] = 71'd8;
        @(negedge clk);
        start_a = 1'b1;
        pwr_valid_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy_before got=%b required=1", busy_a);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready_a, steer_a, busy_a, done_a, pv_a, pidx_a, ppwr_a} !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h required=0",
                     {ready_a, steer_a, busy_a, done_a, pv_a, pidx_a, ppwr_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_random_tab();
        model_a(e_idx, e_pwr);
        scan_a(100, lat, to);
        total++;
        if (to || lat != 13 || pidx_a !== e_idx || ppwr_a !== e_pwr) begin
            bad++;
            $display("FAIL reset_rescan got lat=%0d idx=%0d pwr=%0d required lat=13 idx=%0d pwr=%0d",
                     lat, pidx_a, ppwr_a, e_idx, e_pwr);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit to;
        tab_a[0] = 71'd10; tab_a[1] = 71'd50; tab_a[2] = 71'd30; tab_a[3] = 71'd50;
        scan_a(100, lat, to);
        total++;
        if (to || lat != 13) begin
            bad++;
            $display("FAIL basic_latency got=%0d timeout=%0d required=13", lat, to);
        end
        total++;
        if (pidx_a !== 8'd1) begin
            bad++;
            $display("FAIL basic_peak_idx got=%0d required=1", pidx_a);
        end
        total++;
        if (ppwr_a !== 72'd100) begin
            bad++;
            $display("FAIL basic_peak_pwr got=%0d required=100", ppwr_a);
        end
        total++;
        if (pv_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL basic_flags got valid=%b busy=%b required valid=1 busy=0", pv_a, busy_a);
        end
        @(posedge clk);
        #1;
        total++;
        if (done_a !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse got=%b required=0", done_a);
        end
    endtask

    task automatic test_random();
        logic [7:0]  e_idx;
        logic [71:0] e_pwr;
        logic [7:0]  prev_steer;
        logic        prev_ready;
        int          hs_cnt;
        bit          got;
        bit          extra;
        for (int it = 0; it < 4; it++) begin
            fill_random_tab();
            model_a(e_idx, e_pwr);
            @(negedge clk);
            start_a = 1'b1;
            pwr_valid_a = 1'($urandom_range(0, 1));
            hs_cnt = 0;
            prev_steer = 8'd0;
            prev_ready = 1'b0;
            got = 1'b0;
            for (int n = 0; n < 400 && !got; n++) begin
                @(negedge clk);
                if (steer_a !== prev_steer) begin
                    total++;
                    if (hs_cnt != 2 || prev_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL random_steer_step got hs=%0d ready_before=%b required hs=2 ready_before=0",
                                 hs_cnt, prev_ready);
                    end
                    hs_cnt = 0;
                end
                if (done_a === 1'b1) got = 1'b1;
                start_a = (busy_a === 1'b1 && !got) ? 1'($urandom_range(0, 1)) : 1'b0;
                pwr_valid_a = got ? 1'b0 : 1'($urandom_range(0, 1));
                if (pwr_valid_a === 1'b1 && ready_a === 1'b1) hs_cnt++;
                prev_ready = ready_a;
                prev_steer = steer_a;
            end
            start_a = 1'b0;
            pwr_valid_a = 1'b0;
            total++;
            if (!got || pidx_a !== e_idx || ppwr_a !== e_pwr || pv_a !== 1'b1) begin
                bad++;
                $display("FAIL random_result got done=%0d idx=%0d pwr=%0d required idx=%0d pwr=%0d",
                         got, pidx_a, ppwr_a, e_idx, e_pwr);
            end
            extra = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (busy_a !== 1'b0 || done_a !== 1'b0) extra = 1'b1;
            end
            total++;
            if (extra) begin
                bad++;
                $display("FAIL random_no_extra_scan got activity=1 required=0");
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0]  e_idx;
        logic [71:0] e_pwr;
        bit found;
        bit seen_done;
        int lat;
        bit to;
        fill_random_tab();
        @(negedge clk);
        start_a = 1'b1;
        pwr_valid_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (steer_a === 8'd2) found = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL abort_reach_idx2 got steer=%0d required=2", steer_a);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        total++;
        if (busy_a !== 1'b0 || steer_a !== 8'd0 || pv_a !== 1'b0 || done_a !== 1'b0 || ready_a !== 1'b0) begin
            bad++;
            $display("FAIL abort_state got busy=%b steer=%0d valid=%b done=%b ready=%b required all 0",
                     busy_a, steer_a, pv_a, done_a, ready_a);
        end
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin
            bad++;
            $display("FAIL abort_no_done got activity=1 required=0");
        end
        // Simultaneous start and abort in idle must not start a scan.
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        @(negedge clk);
        total++;
        if (busy_a !== 1'b0 || ready_a !== 1'b0) begin
            bad++;
            $display("FAIL abort_start_tie got busy=%b ready=%b required 0 0", busy_a, ready_a);
        end
        fill_random_tab();
        model_a(e_idx, e_pwr);
        scan_a(100, lat, to);
        total++;
        if (to || lat != 13 || pidx_a !== e_idx || ppwr_a !== e_pwr || pv_a !== 1'b1) begin
            bad++;
            $display("FAIL abort_rescan got lat=%0d idx=%0d pwr=%0d required lat=13 idx=%0d pwr=%0d",
                     lat, pidx_a, ppwr_a, e_idx, e_pwr);
        end
    endtask

    task automatic test_zero();
        int lat;
        bit to;
        bit moved;
        tab_a[0] = 71'd0; tab_a[1] = 71'd0; tab_a[2] = 71'd0; tab_a[3] = 71'd0;
        scan_a(100, lat, to);
        total++;
        if (to || pidx_a !== 8'd0 || ppwr_a !== 72'd0 || pv_a !== 1'b1) begin
            bad++;
            $display("FAIL zero_result got idx=%0d pwr=%0d valid=%b required 0 0 1", pidx_a, ppwr_a, pv_a);
        end
        moved = 1'b0;
        repeat (15) begin
            @(negedge clk);
            fill_random_tab();
            pwr_valid_a = 1'($urandom_range(0, 1));
            if (pidx_a !== 8'd0 || ppwr_a !== 72'd0 || pv_a !== 1'b1) moved = 1'b1;
        end
        pwr_valid_a = 1'b0;
        total++;
        if (moved) begin
            bad++;
            $display("FAIL zero_hold got changed=1 required=0");
        end
    endtask

    task automatic test_big();
        logic [74:0] e_pwr;
        logic [70:0] val;
        int lat;
        bit to;
        val = (71'd1 << 70) - 71'd1;
        e_pwr = 75'(val) * 75'd16;
        pwr_b = val;
        @(negedge clk);
        start_b = 1'b1;
        pwr_valid_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        to = 1'b1;
        for (int n = 1; n <= 4000; n++) begin
            @(posedge clk);
            #1;
            if (done_b === 1'b1) begin
                lat = n;
                to = 1'b0;
                break;
            end
        end
        total++;
        if (to || lat != 3078) begin
            bad++;
            $display("FAIL big_latency got=%0d timeout=%0d required=3078", lat, to);
        end
        total++;
        if (ppwr_b !== e_pwr || pidx_b !== 8'd0 || pv_b !== 1'b1) begin
            bad++;
            $display("FAIL big_result got idx=%0d pwr=%h required idx=0 pwr=%h", pidx_b, ppwr_b, e_pwr);
        end
        pwr_valid_b = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; pwr_valid_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; pwr_valid_b = 1'b0;
        pwr_b = 71'd0;
        for (int a = 0; a < 4; a++) tab_a[a] = 71'd0;
        test_reset();
        test_basic();
        test_random();
        test_abort();
        test_zero();
        test_big();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/doa_peak_search.md
Name: doa_peak_search

Overview:
Downstream consumer of the 4-channel steered-power stage (complex multiply with steering vector, channel sum, |.|^2). Sweeps the steering-vector index across all scan angles. For each angle it accumulates beam power over N_SNAP snapshots and tracks the maximum. After the sweep it reports the peak angle index and its accumulated power. It also drives the steering-vector ROM address feeding the power stage.

Parameters:
POWER_WIDTH, 71, width of incoming power word (2*(2*16+3)+1); treated as unsigned.
N_ANGLES, 181, number of scan angles (index 0..N_ANGLES-1).
ANGLE_BITS, 8, width of angle index; must satisfy 2^ANGLE_BITS >= N_ANGLES.
N_SNAP, 16, snapshots accumulated per angle; power of two, >= 1.
ACC_WIDTH, POWER_WIDTH+log2(N_SNAP), derived localparam, accumulator width; overflow impossible by construction.

Ports:
clk  in  1  system clock, all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle scan request; honoured only in IDLE.
abort  in  1  synchronous scan cancel; wins over start.
pwr_in  in  POWER_WIDTH  steered power for current steer_idx.
pwr_valid  in  1  pwr_in valid this cycle.
pwr_ready  out  1  block accepts pwr_in this cycle (handshake = pwr_valid & pwr_ready).
steer_idx  out  ANGLE_BITS  steering-vector index presented to power stage.
busy  out  1  high from the cycle after start is accepted until DONE is exited.
done  out  1  one-cycle pulse when the result is committed.
peak_valid  out  1  peak_idx/peak_pwr hold a completed result; cleared on start accept or abort.
peak_idx  out  ANGLE_BITS  angle index of maximum accumulated power.
peak_pwr  out  ACC_WIDTH  maximum accumulated power.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; acc, snap_cnt and running max/max_idx 0.
- States: IDLE, ACCUM, COMPARE, DONE. Registered outputs; pwr_ready = (state==ACCUM).
- IDLE: steer_idx=0. On start & !abort: clear acc, snap_cnt, max and max_idx; clear peak_valid; go to ACCUM.
- ACCUM: on each handshake, acc += pwr_in (zero-extended) and snap_cnt++. A handshake with snap_cnt==N_SNAP-1 goes to COMPARE with the final sample included. No handshake means hold.
- COMPARE (1 cycle, pwr_ready=0):
  - Update if steer_idx==0 or acc > max (strict): max<=acc, max_idx<=steer_idx. Ties keep the lowest index.
  - Last angle (steer_idx==N_ANGLES-1): go to DONE.
  - Otherwise: steer_idx++, acc<=0, snap_cnt<=0, back to ACCUM.
- steer_idx changes only on COMPARE exit. The power stage is combinational, so the next accepted pwr_in already reflects the new index.
- DONE (1 cycle): peak_idx<=max_idx, peak_pwr<=max (final compare included); done=1, peak_valid<=1; then IDLE. peak_* held until the next start accept.
- Latency with pwr_valid held high: done asserted N_ANGLES*(N_SNAP+1)+1 cycles after the start-sampling edge. Defaults: 3078.
- start in ACCUM/COMPARE/DONE: ignored, no side effects.
- abort in any non-IDLE state: next cycle IDLE, busy=0, steer_idx=0, no done, peak_valid=0, partial results discarded.
- Simultaneous start & abort in IDLE: stay IDLE.
- pwr_valid outside ACCUM: ignored; no data lost, because the upstream holds its sample until ready.

Decomposition:
- Shared package doa_pkg:
  - POWER_WIDTH, N_ANGLES, ANGLE_BITS and N_SNAP defaults.
  - State encoding constants.
  - A clog2 function for ACC_WIDTH.
- One sub-module, peak_hold:
  - Registered running max/argmax with clear and update-enable.
  - Strict-greater compare with a first-sample force-load.
- The FSM, counters and accumulator stay in the top level.

Test Plan:
1. Reset: assert rst_n=0 mid-scan, asynchronously -> all outputs 0 immediately, state IDLE; after release, start gives a normal scan.
2. N_ANGLES=4, N_SNAP=2, pwr_valid=1, pwr per angle [10,50,30,50] -> peak_idx=1 (tie with 3 loses), peak_pwr=100, done exactly 13 cycles after start, single-cycle pulse.
3. Same config, pwr_valid random ~50%, plus start pulses while busy -> identical result. steer_idx changes only after COMPARE, no extra scans start, pwr_ready=0 in COMPARE.
4. Abort while steer_idx=2 -> next cycle busy=0, steer_idx=0, peak_valid=0, no done. A subsequent start completes with correct result.
5. Default params, pwr_in=2^70-1 on all angles -> peak_pwr=16*(2^70-1) (no wrap), peak_idx=0, done at 3078 cycles.
6. All-zero power -> peak_idx=0, peak_pwr=0, peak_valid=1. peak_* held stable until the next start accept.
